// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with timeout.
// Optional duty8 restoring divider is built when PWM_CAPTURE_DUTY8_EN is defined.
module pwm_capture #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic [7:0]       duty8,
  output logic             duty_valid
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {S_SYNC, S_HIGH, S_LOW} state_t;

  state_t           state, state_nx;
  logic             s1, s2, hist;
  logic [1:0]       fill;
  logic             rise, fall;
  logic [CNT_W-1:0] per_ctr, hi_ctr;
  logic             ld, clr_per, inc_per, inc_hi, capture, set_to;

  // Until three post-reset samples have flowed through, a rise is only the
  // reset value of the pipeline being overwritten, not a real input edge.
  assign rise = s2 & ~hist & (fill == 2'd3);
  assign fall = ~s2 & hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      hist <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_SYNC;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    clr_per  = 1'b0;
    inc_per  = 1'b0;
    inc_hi   = 1'b0;
    capture  = 1'b0;
    set_to   = 1'b0;
    case (state)
      S_SYNC: begin
        if (rise) begin
          ld       = 1'b1;
          state_nx = S_HIGH;
        end else begin
          inc_per = 1'b1;
          set_to  = (per_ctr == TO_VAL);
        end
      end
      S_HIGH: begin
        if (per_ctr == TO_VAL) begin
          set_to   = 1'b1;
          clr_per  = 1'b1;
          state_nx = S_SYNC;
        end else begin
          inc_per = 1'b1;
          if (fall) state_nx = S_LOW;
          else      inc_hi   = 1'b1;
        end
      end
      S_LOW: begin
        if (rise) begin
          capture  = 1'b1;
          ld       = 1'b1;
          state_nx = S_HIGH;
        end else if (per_ctr == TO_VAL) begin
          set_to   = 1'b1;
          clr_per  = 1'b1;
          state_nx = S_SYNC;
        end else begin
          inc_per = 1'b1;
        end
      end
      default: state_nx = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      per_ctr    <= '0;
      hi_ctr     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (ld) begin
        per_ctr <= ONE;
        hi_ctr  <= ONE;
      end else if (clr_per) begin
        per_ctr <= '0;
      end else begin
        if (inc_per && per_ctr != '1) per_ctr <= per_ctr + ONE;
        if (inc_hi && hi_ctr != '1)   hi_ctr  <= hi_ctr + ONE;
      end
      meas_valid <= capture;
      if (capture) begin
        high_cnt   <= hi_ctr;
        period_cnt <= per_ctr;
      end
      if (capture)     timeout <= 1'b0;
      else if (set_to) timeout <= 1'b1;
    end
  end

`ifdef PWM_CAPTURE_DUTY8_EN
  logic [CNT_W:0]   rem, rem_sh, rem_nx;
  logic [CNT_W-1:0] dvs;
  logic [7:0]       quo;
  logic [3:0]       dcnt;
  logic             busy, q_bit;

  // high_cnt < period_cnt, so the remainder never needs its top bit before the shift.
  always_comb begin
    rem_sh = {rem[CNT_W-1:0], 1'b0};
    q_bit  = (rem_sh >= {1'b0, dvs});
    rem_nx = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      dcnt       <= '0;
      busy       <= 1'b0;
      duty8      <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_valid) begin
        rem  <= {1'b0, high_cnt};
        dvs  <= period_cnt;
        dcnt <= 4'd8;
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= rem_nx;
        quo  <= {quo[6:0], q_bit};
        dcnt <= dcnt - 4'd1;
        if (dcnt == 4'd1) begin
          busy       <= 1'b0;
          duty8      <= {quo[6:0], q_bit};
          duty_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign duty8      = 8'h00;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures a PWM waveform on the solar MPPT controller: high time and period, in clock cycles. Used to read back the converter gate drive (loopback of the DPWM output) or an external PWM source into the MPPT control loop. With the divider option compiled in, it also returns an 8-bit duty word on the same scale as the DPWM duty input.

## Interface
- `CNT_W`, 16: width of the high-time and period counters/outputs.
- `TIMEOUT`, 16'hFFFF: cycles without an expected edge before a timeout is declared; must be ≤ 2^CNT_W−1.

- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: synchronous, active-low reset.
- `pwm_in` input 1: asynchronous PWM input.
- `high_cnt` output CNT_W: cycles high in the last complete period.
- `period_cnt` output CNT_W: cycles rise-to-rise in the last complete period.
- `meas_valid` output 1: 1-cycle pulse when `high_cnt`/`period_cnt` update.
- `timeout` output 1: level; no valid PWM activity detected.
- `duty8` output 8: duty scaled to 0..255 (macro only, else 0).
- `duty_valid` output 1: 1-cycle pulse when `duty8` updates (macro only, else 0).

## Operation
- **Input conditioning**
  - `pwm_in` passes through a 2-FF synchronizer plus one history FF; all reset to 0.
  - `rise` = sync & ~hist; `fall` = ~sync & hist.
- **FSM states:** SYNC (reset state), HIGH, LOW.
  - SYNC: discards partial periods. On `rise`: `per_ctr`←1, `hi_ctr`←1, go to HIGH.
  - HIGH: `per_ctr`++ and `hi_ctr`++ each cycle. On `fall`: go to LOW, `hi_ctr` frozen.
  - LOW: `per_ctr`++. On `rise`: `period_cnt`←`per_ctr`, `high_cnt`←`hi_ctr`, pulse `meas_valid`, clear `timeout`, reload both counters to 1, go to HIGH.
- **Counters:** saturate at all-ones; never wrap.
- **Timeout**
  - Condition: `per_ctr` reaches `TIMEOUT` in HIGH or LOW, or no `rise` within `TIMEOUT` cycles in SYNC.
  - Action: `timeout`←1, go to SYNC. Covers both stuck-high (100 %) and stuck-low (0 %).
  - `high_cnt`/`period_cnt` keep their last values.
- **Outputs:** all registered; hold their values between updates.
- **Reset:** all outputs 0, FSM in SYNC, counters 0. A reset during a measurement discards it; the first result after reset needs two rising edges.

## Timing
- A `pwm_in` edge sampled at posedge k asserts `rise`/`fall` at posedge k+2.
- `meas_valid` is high in the cycle after the closing `rise` is detected, and `high_cnt`/`period_cnt` are valid in that same cycle.
- Duty is unaffected by the synchronizer latency, because both edges see the same delay.
- For a DPWM with period 256 and duty D (1..255): `high_cnt`=D, `period_cnt`=256.
- Minimum measurable high or low phase: 1 cycle. Minimum period: 2 cycles.

## Configuration
- **`PWM_CAPTURE_DUTY8_EN` defined:**
  - A sequential restoring divider computes `duty8` = floor(`high_cnt`×256 / `period_cnt`), one quotient bit per cycle.
  - It starts on `meas_valid` and pulses `duty_valid` exactly 9 cycles later (1 load + 8 iterate).
  - A new `meas_valid` during a division aborts it and restarts with the new operands; no `duty_valid` is issued for the aborted division.
  - `high_cnt` < `period_cnt` always holds, so the result fits in 8 bits.
  - `duty8`/`duty_valid` reset to 0.
- **Macro undefined:**
  - No divider logic is built.
  - `duty8` is tied to 8'h00 and `duty_valid` to 0; ports remain present.

## Test plan
- **Normal DPWM:** DPWM source with duty=64, period 256, free-running → from the second rise on, `meas_valid` every 256 cycles with `high_cnt`=64, `period_cnt`=256; with the macro, `duty8`=64 and `duty_valid` 9 cycles after each `meas_valid`.
- **Startup:** release reset mid-high-phase of a duty=200 wave → no `meas_valid` until two full rises; first result `high_cnt`=200, `period_cnt`=256.
- **Duty step:** change duty 32→192 between periods → one period reports 32, the next complete period reports 192; never an intermediate value.
- **Stuck input:** hold `pwm_in`=1 with `TIMEOUT`=300 → `timeout`=1 exactly 300 cycles after the last rise; outputs hold their previous values. Resume PWM → `timeout` clears at the next `meas_valid`.
- **Short period:** 3-cycle period, 1 cycle high → `high_cnt`=1, `period_cnt`=3, `meas_valid` every 3 cycles; with the macro, each division aborts and no `duty_valid` appears.
- **Reset mid-measurement:** `rst`=0 for 1 cycle during LOW → all outputs 0 next cycle; resumes via SYNC.
